// File: rtl/io_port_hub.sv
// io_port_hub
//   I/O port hub between the PicoBlaze port bus and the peripherals (RTC engine,
//   PS/2 controller, VGA register file). It provides:
//   - a contiguous window of read channels,
//   - a write-register bank that is also reachable through k_write_strobe,
//   - sticky event flags that clear when the status port is read,
//   - a masked interrupt request with an acknowledge handshake.
//
// Ports
//   clk, reset      system clock; asynchronous active-high reset
//   port_id         PicoBlaze port address
//   read_strobe     PicoBlaze input strobe (only used for clear-on-read of the flags)
//   write_strobe    PicoBlaze output strobe
//   k_write_strobe  PicoBlaze constant-output strobe (decodes port_id[3:0] only)
//   out_port        PicoBlaze output data
//   in_port         registered read data, valid one cycle after port_id
//   rd_data         flattened read channels, channel i = rd_data[8i+7:8i]
//   evt_pulse       one-cycle event pulses that set the sticky flags
//   wr_regs         flattened write-register contents
//   wr_pulse        one-cycle pulse per register, aligned with its new value
//   interrupt       interrupt request to PicoBlaze
//   interrupt_ack   PicoBlaze interrupt acknowledge
module io_port_hub #(
  parameter int         N_CH        = 12,
  parameter logic [7:0] RD_BASE     = 8'h12,
  parameter int         N_WR        = 8,
  parameter logic [7:0] WR_BASE     = 8'h20,
  parameter bit         K_WR_EN     = 1'b1,
  parameter int         N_EVT       = 4,
  parameter logic [7:0] STATUS_ADDR = 8'h0F,
  parameter logic [7:0] MASK_ADDR   = 8'h0E
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          port_id,
  input  logic                read_strobe,
  input  logic                write_strobe,
  input  logic                k_write_strobe,
  input  logic [7:0]          out_port,
  output logic [7:0]          in_port,
  input  logic [8*N_CH-1:0]   rd_data,
  input  logic [N_EVT-1:0]    evt_pulse,
  output logic [8*N_WR-1:0]   wr_regs,
  output logic [N_WR-1:0]     wr_pulse,
  output logic                interrupt,
  input  logic                interrupt_ack
);

  // The address windows use 8-bit arithmetic, so they must not run past 8'hFF.
  if (int'(RD_BASE) + N_CH > 256) begin : g_rd_window_check
    $error("io_port_hub: read window wraps past 8'hFF");
  end
  if (int'(WR_BASE) + N_WR > 256) begin : g_wr_window_check
    $error("io_port_hub: write window wraps past 8'hFF");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  state_t             state;
  logic [N_EVT-1:0]   flags;
  logic [N_EVT-1:0]   mask;
  logic [7:0]         rd_mux;
  logic [N_WR-1:0]    wr_hit;
  logic               mask_wr;
  logic               status_clr;
  logic               pending;

  assign mask_wr    = write_strobe && (port_id == MASK_ADDR);
  assign status_clr = read_strobe && (port_id == STATUS_ADDR);
  assign pending    = |(flags & mask);

  // Read decode: status, then mask, then the channel window; anything else reads 0.
  always_comb begin
    rd_mux = 8'h00;
    if (port_id == STATUS_ADDR) begin
      rd_mux = 8'(flags);
    end else if (port_id == MASK_ADDR) begin
      rd_mux = 8'(mask);
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (port_id == RD_BASE + 8'(i)) rd_mux = rd_data[8*i +: 8];
      end
    end
  end

  // Write decode: write_strobe takes priority; k_write_strobe only sees port_id[3:0].
  always_comb begin
    wr_hit = '0;
    for (int j = 0; j < N_WR; j++) begin
      if (write_strobe) begin
        if (port_id == WR_BASE + 8'(j)) wr_hit[j] = 1'b1;
      end else if (K_WR_EN && k_write_strobe && (port_id[3:0] == 4'(j))) begin
        wr_hit[j] = 1'b1;
      end
    end
  end

  // Register stage: read data, flags, mask and write bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_port  <= 8'h00;
      flags    <= '0;
      mask     <= '0;
      wr_regs  <= '0;
      wr_pulse <= '0;
    end else begin
      // in_port captures the pre-clear flags; a new event beats the clear.
      in_port  <= rd_mux;
      flags    <= (status_clr ? '0 : flags) | evt_pulse;
      wr_pulse <= wr_hit;
      if (mask_wr) mask <= out_port[N_EVT-1:0];
      for (int j = 0; j < N_WR; j++) begin
        if (wr_hit[j]) wr_regs[8*j +: 8] <= out_port;
      end
    end
  end

  // Interrupt handshake. After an acknowledge the request stays quiet until
  // every masked flag has been read-cleared, so events during service do not
  // cause a second request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      interrupt <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pending) begin
            state     <= S_REQ;
            interrupt <= 1'b1;
          end
        end
        S_REQ: begin
          if (mask_wr && (out_port[N_EVT-1:0] == '0)) begin
            state     <= S_IDLE;
            interrupt <= 1'b0;
          end else if (interrupt_ack) begin
            state     <= S_SERVICE;
            interrupt <= 1'b0;
          end
        end
        S_SERVICE: begin
          interrupt <= 1'b0;
          if (!pending) state <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_hub.sv
module tb_io_port_hub;

  localparam int N_CH  = 12;
  localparam int N_WR  = 8;
  localparam int N_EVT = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [7:0]          port_id = 8'h00;
  logic                read_strobe = 1'b0;
  logic                write_strobe = 1'b0;
  logic                k_write_strobe = 1'b0;
  logic [7:0]          out_port = 8'h00;
  logic [7:0]          in_port;
  logic [8*N_CH-1:0]   rd_data = '0;
  logic [N_EVT-1:0]    evt_pulse = '0;
  logic [8*N_WR-1:0]   wr_regs;
  logic [N_WR-1:0]     wr_pulse;
  logic                interrupt;
  logic                interrupt_ack = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  io_port_hub dut (
    .clk(clk), .reset(reset), .port_id(port_id), .read_strobe(read_strobe),
    .write_strobe(write_strobe), .k_write_strobe(k_write_strobe), .out_port(out_port),
    .in_port(in_port), .rd_data(rd_data), .evt_pulse(evt_pulse), .wr_regs(wr_regs),
    .wr_pulse(wr_pulse), .interrupt(interrupt), .interrupt_ack(interrupt_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // Behavioural model of what the CPU should observe.
  logic [7:0]        m_in;
  logic [8*N_WR-1:0] m_wr;
  logic [N_WR-1:0]   m_wrp;
  logic [3:0]        m_flags, m_mask;
  bit                m_irq;   // request currently raised
  bit                m_svc;   // acknowledged, waiting for masked flags to drain

  function automatic void model_reset();
    m_in = 8'h00; m_wr = '0; m_wrp = '0; m_flags = 4'h0; m_mask = 4'h0;
    m_irq = 1'b0; m_svc = 1'b0;
  endfunction

  function automatic void model_step();
    int p;
    bit pend;
    logic [7:0] rv;
    logic [3:0] nf;
    p    = int'(port_id);
    pend = |(m_flags & m_mask);
    if (p == 15)                      rv = {4'h0, m_flags};
    else if (p == 14)                 rv = {4'h0, m_mask};
    else if (p >= 18 && p < 18+N_CH)  rv = rd_data[8*(p-18) +: 8];
    else                              rv = 8'h00;
    nf = (read_strobe && p == 15) ? 4'h0 : m_flags;
    nf = nf | evt_pulse;
    if (m_irq) begin
      if (write_strobe && p == 14 && out_port[3:0] == 4'h0) m_irq = 1'b0;
      else if (interrupt_ack) begin m_irq = 1'b0; m_svc = 1'b1; end
    end else if (m_svc) begin
      if (!pend) m_svc = 1'b0;
    end else if (pend) begin
      m_irq = 1'b1;
    end
    m_wrp = '0;
    if (write_strobe) begin
      if (p >= 32 && p < 32+N_WR) begin
        m_wr[8*(p-32) +: 8] = out_port;
        m_wrp[p-32] = 1'b1;
      end
      if (p == 14) m_mask = out_port[3:0];
    end else if (k_write_strobe && (p % 16) < N_WR) begin
      m_wr[8*(p%16) +: 8] = out_port;
      m_wrp[p%16] = 1'b1;
    end
    m_flags = nf;
    m_in    = rv;
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) model_reset();
    else       model_step();
  end

  always @(posedge clk) begin
    #1;
    if (chk_en && !reset) begin
      check("cmp_in_port",   64'(in_port),   64'(m_in));
      check("cmp_wr_regs",   64'(wr_regs),   64'(m_wr));
      check("cmp_wr_pulse",  64'(wr_pulse),  64'(m_wrp));
      check("cmp_interrupt", 64'(interrupt), 64'(m_irq));
    end
  end

  task automatic idle();
    read_strobe = 1'b0; write_strobe = 1'b0; k_write_strobe = 1'b0;
    evt_pulse = '0; interrupt_ack = 1'b0;
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(logic [7:0] a, logic [7:0] d);
    idle(); port_id = a; out_port = d; write_strobe = 1'b1; tick(); idle();
  endtask

  task automatic rd(logic [7:0] a);
    idle(); port_id = a; read_strobe = 1'b1; tick(); idle();
  endtask

  task automatic evt(logic [3:0] e);
    idle(); evt_pulse = e; tick(); idle();
  endtask

  task automatic wait_irq(string name, int budget);
    int k;
    k = 0;
    while (!interrupt && k < budget) begin tick(); k++; end
    check(name, 64'(interrupt), 64'd1);
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("rst_interrupt", 64'(interrupt), 64'd0);
    check("rst_wr_regs",   64'(wr_regs),   64'd0);
    check("rst_wr_pulse",  64'(wr_pulse),  64'd0);
    check("rst_in_port",   64'(in_port),   64'd0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int r;
    model_reset();
    idle();
    tick(3);
    check("reset_in_port",   64'(in_port),   64'd0);
    check("reset_wr_regs",   64'(wr_regs),   64'd0);
    check("reset_interrupt", 64'(interrupt), 64'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Address sweep over the whole port space.
    for (int i = 0; i < N_CH; i++) rd_data[8*i +: 8] = 8'hA0 + 8'(i);
    for (int p = 0; p < 256; p++) begin
      port_id = 8'(p);
      tick();
      if (p == 8'h12) check("sweep_ch0",   64'(in_port), 64'hA0);
      if (p == 8'h1D) check("sweep_ch11",  64'(in_port), 64'hAB);
      if (p == 8'h1E) check("sweep_above", 64'(in_port), 64'h00);
      if (p == 8'h11) check("sweep_below", 64'(in_port), 64'h00);
      if (p == 8'hFF) check("sweep_top",   64'(in_port), 64'h00);
    end

    // Write bank through write_strobe and k_write_strobe.
    wr(8'h23, 8'h5A);
    check("wr_reg3",      64'(wr_regs[31:24]), 64'h5A);
    check("wr_pulse3",    64'(wr_pulse),       64'h08);
    tick();
    check("wr_pulse_end", 64'(wr_pulse),       64'h00);
    port_id = 8'hF3; out_port = 8'h11; k_write_strobe = 1'b1; tick(); idle();
    check("kwr_reg3",     64'(wr_regs[31:24]), 64'h11);
    check("kwr_pulse3",   64'(wr_pulse),       64'h08);

    // Sticky flags with clear-on-read, including set-wins-over-clear.
    evt(4'b0010);
    rd(8'h0F);
    check("status_rd",  64'(in_port), 64'h02);
    tick();
    check("status_clr", 64'(in_port), 64'h00);
    evt(4'b0010);
    port_id = 8'h0F; read_strobe = 1'b1; evt_pulse = 4'b0010; tick(); idle();
    check("status_rd2", 64'(in_port), 64'h02);
    tick();
    check("status_set_wins", 64'(in_port), 64'h02);
    rd(8'h0F);
    tick(2);

    // Interrupt handshake.
    wr(8'h0E, 8'h01);
    evt(4'b0001);
    wait_irq("irq_rise", 2);
    interrupt_ack = 1'b1; tick(); idle();
    check("irq_ack_drop", 64'(interrupt), 64'd0);
    evt(4'b0001);
    tick(3);
    check("irq_no_rereq", 64'(interrupt), 64'd0);
    rd(8'h0F);
    check("irq_status", 64'(in_port), 64'h01);
    tick(2);
    evt(4'b0001);
    wait_irq("irq_reassert", 2);
    interrupt_ack = 1'b1; tick(); idle();
    rd(8'h0F);
    tick(2);

    // Masked-off event and mask readback.
    evt(4'b0100);
    tick(3);
    check("irq_masked", 64'(interrupt), 64'd0);
    rd(8'h0E);
    check("mask_rd", 64'(in_port), 64'h01);
    rd(8'h0F);
    check("masked_flag", 64'(in_port), 64'h04);
    tick(2);

    // Request withdrawn by writing a zero mask.
    evt(4'b0001);
    wait_irq("irq_req", 2);
    wr(8'h0E, 8'h00);
    check("irq_withdraw", 64'(interrupt), 64'd0);
    rd(8'h0F);
    tick(2);

    // Asynchronous reset while requesting.
    wr(8'h0E, 8'h0F);
    evt(4'hF);
    wait_irq("irq_before_rst", 2);
    wr(8'h21, 8'h77);
    async_reset();
    rd(8'h0F);
    check("flags_after_rst", 64'(in_port), 64'h00);

    // Randomized traffic checked every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      idle();
      rd_data = {$urandom, $urandom, $urandom};
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: port_id = 8'($urandom);
        3:       port_id = 8'h0F;
        4:       port_id = 8'h0E;
        5, 6:    port_id = 8'h12 + 8'($urandom_range(0, N_CH-1));
        7, 8:    port_id = 8'h20 + 8'($urandom_range(0, N_WR-1));
        default: port_id = 8'($urandom);
      endcase
      out_port = 8'($urandom);
      if (port_id == 8'h0E && $urandom_range(0, 1) == 0) out_port[3:0] = 4'h0;
      write_strobe   = ($urandom_range(0, 3) == 0);
      k_write_strobe = !write_strobe && ($urandom_range(0, 7) == 0);
      read_strobe    = ($urandom_range(0, 4) == 0);
      for (int b = 0; b < N_EVT; b++) evt_pulse[b] = ($urandom_range(0, 7) == 0);
      interrupt_ack  = interrupt && ($urandom_range(0, 2) == 0);
      if (c == 1500) begin
        idle();
        async_reset();
      end else begin
        tick();
      end
    end

    idle();
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/io_port_hub.md
Name: io_port_hub

Overview:
- Parametrised I/O port hub between the PicoBlaze port bus (port_id / in_port / out_port / strobes) and the peripherals: RTC read/write engine, PS/2 controller, VGA register file.
- Replaces hand-written per-address input-port case decoding.
- Adds a contiguous read-channel window, a write-register bank with constant-port (k_write_strobe) support, sticky event flags with clear-on-read, and a masked interrupt request with acknowledge handshake.

Parameters:
- N_CH, 12, number of 8-bit read channels (1..32)
- RD_BASE, 8'h12, port_id of read channel 0; channel i at RD_BASE+i
- N_WR, 8, number of 8-bit write registers (1..16)
- WR_BASE, 8'h20, port_id of write register 0; register j at WR_BASE+j
- K_WR_EN, 1, 1 = k_write_strobe writes register j when port_id[3:0]==j
- N_EVT, 4, number of event inputs (1..8)
- STATUS_ADDR, 8'h0F, read port of the event flag register (clear-on-read)
- MASK_ADDR, 8'h0E, read/write port of the interrupt mask register

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- port_id  in  8  PicoBlaze port address
- read_strobe  in  1  PicoBlaze input strobe
- write_strobe  in  1  PicoBlaze output strobe
- k_write_strobe  in  1  PicoBlaze constant-output strobe
- out_port  in  8  PicoBlaze output data
- in_port  out  8  registered read data to PicoBlaze
- rd_data  in  8*N_CH  flattened read channels; channel i = bits [8i+7:8i]
- evt_pulse  in  N_EVT  one-cycle event pulses (e.g. RTC transfer done, key ready)
- wr_regs  out  8*N_WR  flattened write-register contents
- wr_pulse  out  N_WR  one-cycle pulse when register j is written
- interrupt  out  1  interrupt request to PicoBlaze
- interrupt_ack  in  1  PicoBlaze interrupt acknowledge

Behaviour:
- Reset values (asynchronous): in_port=0, wr_regs=0, wr_pulse=0, flags=0, mask=0, interrupt=0, FSM=IDLE.
- Read mux, registered, 1-cycle latency from port_id:
  - Decode priority: STATUS_ADDR -> {0, flags}; then MASK_ADDR -> {0, mask}; then RD_BASE..RD_BASE+N_CH-1 -> rd_data channel; otherwise 8'h00 (never X).
  - Address arithmetic is 8-bit; the window must not wrap past 8'hFF (elaboration check).
- Event flags:
  - flags[k] is set on evt_pulse[k].
  - Cleared on read_strobe=1 with port_id==STATUS_ADDR.
  - A set in the same cycle as the clear wins: that flag stays 1.
  - The value returned to the CPU is the registered pre-clear value.
- Write bank:
  - write_strobe=1 with port_id in [WR_BASE, WR_BASE+N_WR) loads out_port into register j at the next edge; wr_pulse[j]=1 for exactly that cycle.
  - write_strobe=1 with port_id==MASK_ADDR loads mask <= out_port[N_EVT-1:0].
  - If K_WR_EN=1, k_write_strobe=1 with port_id[3:0]==j (j<N_WR) loads register j and pulses wr_pulse[j].
  - k_write_strobe never writes the mask.
  - write_strobe and k_write_strobe never coincide; if both are asserted, write_strobe has priority.
- Interrupt FSM (pending = |(flags & mask)):
  - IDLE: interrupt=0; when pending -> REQ.
  - REQ: interrupt=1; on interrupt_ack -> SERVICE (interrupt drops the next cycle).
  - SERVICE: interrupt=0; when pending==0 -> IDLE. A new event arriving during SERVICE keeps pending high, so no re-request until all masked flags are read-cleared.
  - Writing mask=0 while in REQ -> IDLE with interrupt=0 (request withdrawn).
- Reset asserted mid-operation: all state returns to reset values immediately; pending flags are lost.

Test Plan:
- Reset, then sweep port_id over 8'h00..8'hFF with rd_data channel i = 8'hA0+i -> in_port equals 8'hA0+i exactly one cycle after port_id = RD_BASE+i; all unmapped addresses return 8'h00.
- write_strobe, port_id=8'h23, out_port=8'h5A -> wr_regs register 3 = 8'h5A and wr_pulse[3] high for one cycle; k_write_strobe, port_id=8'hF3, out_port=8'h11 -> register 3 = 8'h11.
- evt_pulse[1] pulse, then read_strobe at STATUS_ADDR -> in_port = 8'h02 and flags = 0 afterwards; repeat with evt_pulse[1] in the same cycle as the clear -> flag remains 1.
- mask=8'h01, evt_pulse[0] -> interrupt rises within 2 cycles; interrupt_ack -> interrupt 0 the next cycle; a second evt_pulse[0] before the status read -> no new request; after the status read, a third evt_pulse[0] -> interrupt reasserts.
- evt_pulse[2] with mask=8'h01 -> interrupt stays 0; reading MASK_ADDR returns 8'h01.
- Assert reset in REQ with flags=8'h0F -> interrupt, flags and wr_regs all 0 immediately, without waiting for a clock edge.
